// File: rtl/pp_reader_if.sv
// pp_reader_if: read port towards the ping-pong buffer plus the byte stream
// towards the downstream QOI stage, bundled for the pp_reader sequencer.
// master = pp_reader side, slave = buffer/downstream side.
interface pp_reader_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_cs;
   logic [7:0]        rd_data;
   logic [7:0]        out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   modport master (
      output rd_addr, rd_cs, out_data, out_valid, out_last,
      input  rd_data, out_ready
   );

   modport slave (
      input  rd_addr, rd_cs, out_data, out_valid, out_last,
      output rd_data, out_ready
   );
endinterface

// File: rtl/pp_reader.sv
// pp_reader: read-side sequencer for the QOI ping-pong buffer.
// Waits for a bank-select toggle, sweeps every address of the exposed bank
// and returns the bytes as a valid/ready stream. Reads are only issued when
// the output FIFO has room for every byte already in flight, so the one-cycle
// SRAM latency never loses or duplicates a byte under backpressure.
// Optional build macro: PP_READER_STATS_EN adds bank_count / stall_count.
module pp_reader #(
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel_i,
   pp_reader_if.master bus,
   output logic        busy
`ifdef PP_READER_STATS_EN
   ,
   output logic [15:0] bank_count,
   output logic [15:0] stall_count
`endif
);
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [7:0]        byte_t;
   typedef enum logic {WAIT_SWAP, READ} state_t;

   localparam int    PTR_W     = $clog2(FIFO_DEPTH);
   localparam int    CNT_W     = $clog2(FIFO_DEPTH + 1);
   localparam addr_t ADDR_LAST = '1;

   state_t            state_reg;
   addr_t             addr_reg;
   logic              sel_seen_reg;
   logic              inflight_reg;
   logic              inflight_last_reg;
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   byte_t             data_reg [FIFO_DEPTH];
   logic              last_reg [FIFO_DEPTH];

   logic                  issue;
   logic                  push;
   logic                  pop;
   logic                  fifo_valid;
   logic                  head_last;
   logic [FIFO_DEPTH-1:0] wr_en;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Credit check from registered terms only; out_ready stays out of the rd_cs path.
   always_comb begin
      issue      = (state_reg == READ) &&
                   ((int'(count_reg) + int'(inflight_reg)) < FIFO_DEPTH);
      push       = inflight_reg;
      fifo_valid = (count_reg != '0);
      pop        = fifo_valid && bus.out_ready;
      head_last  = fifo_valid && last_reg[rd_ptr_reg];
   end

   assign bus.rd_cs     = issue;
   assign bus.rd_addr   = addr_reg;
   assign bus.out_valid = fifo_valid;
   assign bus.out_data  = fifo_valid ? data_reg[rd_ptr_reg] : '0;
   assign bus.out_last  = head_last;
   assign busy          = (state_reg == READ) || fifo_valid;

   // Per-entry write strobes for the FIFO storage.
   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
         assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
      end
   endgenerate

   // Sequencer: follow the bank select, sweep the bank once, then wait again.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= WAIT_SWAP;
         addr_reg     <= '0;
         sel_seen_reg <= 1'b0;
      end else begin
         case (state_reg)
            WAIT_SWAP: begin
               if (sel_i != sel_seen_reg) begin
                  sel_seen_reg <= sel_i;
                  addr_reg     <= '0;
                  state_reg    <= READ;
               end
            end
            READ: begin
               // A toggle seen here is a protocol error and is deliberately ignored.
               if (issue) begin
                  addr_reg <= addr_reg + addr_t'(1);
                  if (addr_reg == ADDR_LAST) state_reg <= WAIT_SWAP;
               end
            end
            default: state_reg <= WAIT_SWAP;
         endcase
      end
   end

   // Track the single outstanding SRAM read and whether it is the bank's last byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_reg      <= 1'b0;
         inflight_last_reg <= 1'b0;
      end else begin
         inflight_reg      <= issue;
         inflight_last_reg <= issue && (addr_reg == ADDR_LAST);
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave the count alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // FIFO storage: capture returning read data with its last flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            data_reg[i] <= '0;
            last_reg[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (wr_en[i]) begin
               data_reg[i] <= bus.rd_data;
               last_reg[i] <= inflight_last_reg;
            end
         end
      end
   end

`ifdef PP_READER_STATS_EN
   // Completed banks (wrapping) and backpressure cycles (saturating).
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_count  <= '0;
         stall_count <= '0;
      end else begin
         if (pop && head_last) bank_count <= bank_count + 16'd1;
         if (fifo_valid && !bus.out_ready && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
      end
   end
`endif
endmodule
